spi_flash_seq: RTL

- Sequencer that lets the CPU use external SPI NOR flash as ordinary 16-bit memory in the upper address region (addr >= BASE).
- Turns one CPU bus access into a complete flash transaction: command byte, 24-bit byte address, then data bytes.
- Drives the SoC's byte-level SPI engine through its load/unload handshake.
- Holds the CPU with ready low until the word is complete.

---
 rtl/spi_flash_seq_pkg.sv | 33 +++
 rtl/spi_flash_seq_byte_ctl.sv | 69 ++++++
 rtl/spi_flash_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/spi_flash_seq_pkg.sv
// Shared constants, state encoding and byte-list helper for the SPI flash sequencer.
package spi_flash_seq_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;

  localparam int READ_LEN = 6;
  localparam int WREN_LEN = 1;
  localparam int PP_LEN   = 6;

  typedef enum logic [2:0] {IDLE, CS_LOW, LOAD, WAIT, UNLOAD, NEXT, CS_HIGH, DONE} state_t;

  // Byte idx of the current command: WREN alone, or READ/PP followed by address and data.
  function automatic logic [7:0] seq_byte(input logic wr, input logic wren,
                                          input logic [2:0] idx, input logic [23:0] a,
                                          input logic [15:0] d);
    logic [7:0] b;
    b = 8'h00;
    if (wren) b = CMD_WREN;
    else begin
      case (idx)
        3'd0:    b = wr ? CMD_PP : CMD_READ;
        3'd1:    b = a[23:16];
        3'd2:    b = a[15:8];
        3'd3:    b = a[7:0];
        3'd4:    b = wr ? d[15:8] : 8'h00;
        3'd5:    b = wr ? d[7:0]  : 8'h00;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction
endpackage

// File: rtl/spi_flash_seq_byte_ctl.sv
// One-byte load/wait/unload handshake with the SPI engine, including the busy timeout.
module spi_byte_ctl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  output logic       done,
  output logic [7:0] rx,
  output logic       timeout,
  output logic       spi_load,
  output logic       spi_unload,
  output logic [7:0] spi_txd,
  input  logic [7:0] spi_rxd,
  input  logic       spi_busy
);
  typedef enum logic [1:0] {B_IDLE, B_LOAD, B_WAIT, B_UNLOAD} phase_t;

  phase_t     phase;
  logic       skip;
  logic [7:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= B_IDLE;
      skip       <= 1'b0;
      tcnt       <= 8'd0;
      done       <= 1'b0;
      rx         <= 8'h00;
      timeout    <= 1'b0;
      spi_load   <= 1'b0;
      spi_unload <= 1'b0;
      spi_txd    <= 8'h00;
    end else begin
      spi_load   <= 1'b0;
      spi_unload <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      case (phase)
        B_IDLE: if (start) begin
          spi_load <= 1'b1;
          spi_txd  <= tx;
          phase    <= B_LOAD;
        end
        B_LOAD: begin
          skip  <= 1'b1;
          tcnt  <= 8'd0;
          phase <= B_WAIT;
        end
        // First wait cycle is blind: the engine may not have raised busy yet.
        B_WAIT: begin
          if (skip) skip <= 1'b0;
          else if (!spi_busy) begin
            spi_unload <= 1'b1;
            done       <= 1'b1;
            rx         <= spi_rxd;
            phase      <= B_UNLOAD;
          end else if (tcnt == 8'(TIMEOUT)) begin
            timeout <= 1'b1;
            phase   <= B_IDLE;
          end else tcnt <= tcnt + 8'd1;
        end
        B_UNLOAD: phase <= B_IDLE;
        default:  phase <= B_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/spi_flash_seq.sv
// Maps CPU word accesses above BASE onto SPI NOR READ / WREN+PP transactions.
module spi_flash_seq
  import spi_flash_seq_pkg::*;
#(
  parameter logic [11:0] BASE    = 12'h020,
  parameter int          CS_GAP  = 2,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rdwr,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        spi_load,
  output logic        spi_unload,
  output logic [7:0]  spi_txd,
  input  logic [7:0]  spi_rxd,
  input  logic        spi_busy,
  output logic        ssn
);
  state_t      state;
  logic        wr_q, wren_q, abort_q;
  logic [23:0] a_q;
  logic [15:0] d_q;
  logic [2:0]  bidx;
  logic [3:0]  gcnt;
  logic [11:0] off;
  logic [7:0]  tx_byte, byte_rx;
  logic        byte_done, byte_to, last_byte;

  assign off       = addr - BASE;
  assign tx_byte   = seq_byte(wr_q, wren_q, bidx, a_q, d_q);
  assign last_byte = wren_q ? (bidx == 3'(WREN_LEN - 1)) :
                     wr_q   ? (bidx == 3'(PP_LEN - 1))   : (bidx == 3'(READ_LEN - 1));

  spi_byte_ctl #(.TIMEOUT(TIMEOUT)) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (state == LOAD),
    .tx         (tx_byte),
    .done       (byte_done),
    .rx         (byte_rx),
    .timeout    (byte_to),
    .spi_load   (spi_load),
    .spi_unload (spi_unload),
    .spi_txd    (spi_txd),
    .spi_rxd    (spi_rxd),
    .spi_busy   (spi_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ssn     <= 1'b1;
      rdata   <= 16'h0000;
      ready   <= 1'b0;
      err     <= 1'b0;
      wr_q    <= 1'b0;
      wren_q  <= 1'b0;
      abort_q <= 1'b0;
      a_q     <= 24'h0;
      d_q     <= 16'h0;
      bidx    <= 3'd0;
      gcnt    <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          wr_q    <= rdwr;
          wren_q  <= rdwr;
          a_q     <= {11'b0, off, 1'b0};
          d_q     <= wdata;
          bidx    <= 3'd0;
          abort_q <= 1'b0;
          ssn     <= 1'b0;
          state   <= CS_LOW;
        end
        CS_LOW: state <= LOAD;
        LOAD:   state <= WAIT;
        WAIT: begin
          if (byte_to) begin
            abort_q <= 1'b1;
            ssn     <= 1'b1;
            gcnt    <= 4'd0;
            state   <= CS_HIGH;
          end else if (byte_done) begin
            // Read data bytes sit at positions 4 and 5 of the READ list.
            if (!wr_q && bidx == 3'd4) rdata[15:8] <= byte_rx;
            if (!wr_q && bidx == 3'd5) rdata[7:0]  <= byte_rx;
            state <= UNLOAD;
          end
        end
        UNLOAD: state <= NEXT;
        NEXT: begin
          if (last_byte) begin
            ssn   <= 1'b1;
            gcnt  <= 4'd0;
            state <= CS_HIGH;
          end else begin
            bidx  <= bidx + 3'd1;
            state <= LOAD;
          end
        end
        CS_HIGH: begin
          if (gcnt == 4'(CS_GAP - 1)) begin
            if (wren_q && !abort_q) begin
              wren_q <= 1'b0;
              bidx   <= 3'd0;
              ssn    <= 1'b0;
              state  <= CS_LOW;
            end else begin
              ready <= 1'b1;
              err   <= abort_q;
              state <= DONE;
            end
          end else gcnt <= gcnt + 4'd1;
        end
        DONE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
